mac_stream_sequencer: RTL

- Sequences the shared 8x8 signed multiply-accumulate unit (unsigned A, signed B, 18-bit accumulator).
- Accepts a valid/ready stream of operand pairs grouped into vectors by in_last.
- Drives the MAC's dataa, datab, clken and sload inputs, inserts the flush cycle, and captures each dot product into a held result register with valid/ready output.
- Sits between the operand fetch logic and the result consumer.

---
 rtl/mac_stream_sequencer_if.sv | 35 +++
 rtl/mac_stream_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mac_stream_sequencer_if.sv
// Bundle of the operand stream, MAC drive/feedback and result stream signals.
// slave is the sequencer's view; master is the surrounding logic
// (operand fetch, MAC, result consumer).
interface mac_stream_sequencer_if #(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic [7:0]       mac_dataa;
    logic [7:0]       mac_datab;
    logic             mac_clken;
    logic             mac_sload;
    logic [17:0]      mac_adder_out;
    logic             res_valid;
    logic             res_ready;
    logic [17:0]      res_data;
    logic [CNT_W-1:0] res_len;
    logic             res_trunc;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_last, mac_adder_out, res_ready,
        output in_ready, mac_dataa, mac_datab, mac_clken, mac_sload,
               res_valid, res_data, res_len, res_trunc, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_last, mac_adder_out, res_ready,
        input  in_ready, mac_dataa, mac_datab, mac_clken, mac_sload,
               res_valid, res_data, res_len, res_trunc, busy
    );
endinterface

// File: rtl/mac_stream_sequencer.sv
// Sequences a shared 8x8 (unsigned A x signed B) multiply-accumulate unit
// over a valid/ready operand stream. The MAC registers its operands on a
// clken edge and folds the previously registered product into the
// accumulator on the same edge, so each vector needs one trailing DRAIN beat
// with zero operands. Those zeros also become the product discarded by the
// next vector's sload edge, which keeps vectors independent.
module mac_stream_sequencer #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic                  clk,
    input  logic                  aclr,
    mac_stream_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        CAPT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trunc_q, trunc_d;
    logic [17:0]      res_data_q;
    logic [CNT_W-1:0] res_len_q;
    logic             res_trunc_q;

    logic             in_ready;
    logic             accept;
    logic             at_max;

    // Beats are only taken in IDLE/ACC, and never while reset is asserted.
    assign in_ready = !aclr && ((state_q == IDLE) || (state_q == ACC));
    assign accept   = in_ready && bus.in_valid;
    // The beat being accepted in ACC is beat MAX_LEN.
    assign at_max   = (cnt_q == LAST_IDX);

    // State, beat counter and truncation flag registers.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    // Next-state, counter and truncation flag logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = CNT_W'(1);
                    if (bus.in_last || (MAX_LEN == 1)) begin
                        state_d = DRAIN;
                        trunc_d = (MAX_LEN == 1) && !bus.in_last;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.in_last || at_max) begin
                        state_d = DRAIN;
                    end
                    if (at_max && !bus.in_last) begin
                        trunc_d = 1'b1;
                    end
                end
            end
            DRAIN: state_d = CAPT;
            CAPT:  state_d = OUT;
            OUT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                    trunc_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MAC drive: pass operands on accepted beats, zeros with clken in DRAIN.
    always_comb begin
        bus.mac_clken = 1'b0;
        bus.mac_sload = 1'b0;
        bus.mac_dataa = 8'd0;
        bus.mac_datab = 8'd0;
        if (accept) begin
            bus.mac_clken = 1'b1;
            bus.mac_sload = (state_q == IDLE);
            bus.mac_dataa = bus.in_a;
            bus.mac_datab = bus.in_b;
        end else if (state_q == DRAIN) begin
            bus.mac_clken = 1'b1;
        end
    end

    // Result holding register, loaded once the accumulator has settled.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            res_data_q  <= '0;
            res_len_q   <= '0;
            res_trunc_q <= 1'b0;
        end else if (state_q == CAPT) begin
            res_data_q  <= bus.mac_adder_out;
            res_len_q   <= cnt_q;
            res_trunc_q <= trunc_q;
        end
    end

    // Status and result outputs.
    always_comb begin
        bus.in_ready  = in_ready;
        bus.res_valid = (state_q == OUT);
        bus.res_data  = res_data_q;
        bus.res_len   = res_len_q;
        bus.res_trunc = res_trunc_q;
        bus.busy      = (state_q != IDLE);
    end

endmodule
